// File: rtl/wupr_mb_if.sv
// wupr_mb_if: write-observe, refresh request/response and bank-clear handshakes of the write-usage peak tracker
interface wupr_mb_if #(
  parameter int ROW_WIDTH = 16,
  parameter int BANK_BITS = 2,
  parameter int CNT_WIDTH = 32
);
  logic                 skip_en;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [BANK_BITS-1:0] wr_bank;
  logic [ROW_WIDTH-1:0] wr_row;
  logic                 ref_req_valid;
  logic                 ref_req_ready;
  logic [BANK_BITS-1:0] ref_bank;
  logic                 ref_rsp_valid;
  logic [BANK_BITS-1:0] ref_rsp_bank;
  logic [ROW_WIDTH-1:0] ref_rsp_row;
  logic                 ref_rsp_dummy;
  logic                 clr_valid;
  logic                 clr_ready;
  logic [BANK_BITS-1:0] clr_bank;
  logic                 clr_done;
  logic [CNT_WIDTH-1:0] dummy_cnt;
  modport master (
    output skip_en, wr_valid, wr_bank, wr_row, ref_req_valid, ref_bank, clr_valid, clr_bank,
    input  wr_ready, ref_req_ready, ref_rsp_valid, ref_rsp_bank, ref_rsp_row, ref_rsp_dummy,
           clr_ready, clr_done, dummy_cnt
  );
  modport slave (
    input  skip_en, wr_valid, wr_bank, wr_row, ref_req_valid, ref_bank, clr_valid, clr_bank,
    output wr_ready, ref_req_ready, ref_rsp_valid, ref_rsp_bank, ref_rsp_row, ref_rsp_dummy,
           clr_ready, clr_done, dummy_cnt
  );
endinterface

// File: rtl/wupr_mb.sv
// wupr_mb: per-bank/segment peak-written-row tracker deciding auto vs dummy refresh
module wupr_mb #(
  parameter int ROW_WIDTH = 16,
  parameter int SEG_BITS  = 6,
  parameter int BANKS     = 4,
  parameter int CNT_WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  wupr_mb_if.slave bus
);
  localparam int OFF_BITS  = ROW_WIDTH - SEG_BITS;
  localparam int BANK_BITS = BANKS > 1 ? $clog2(BANKS) : 1;
  localparam int SEGS      = 1 << SEG_BITS;
  localparam logic [BANK_BITS:0] BANK_LIM = (BANK_BITS+1)'(BANKS);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [OFF_BITS-1:0]  spr [BANKS][SEGS];
  logic [SEGS-1:0]      touched [BANKS];
  logic [ROW_WIDTH-1:0] rcnt [BANKS];
  logic [SEG_BITS-1:0]  clr_idx;
  logic [BANK_BITS-1:0] clr_sel;
  logic                 idle, w_ok, r_ok, c_ok, w_bank_ok, r_bank_ok, c_bank_ok;
  logic [BANK_BITS-1:0] w_b, r_b;
  logic [SEG_BITS-1:0]  w_seg, r_seg;
  logic [OFF_BITS-1:0]  w_off, r_off, w_spr, w_new, spr_eff;
  logic [ROW_WIDTH-1:0] r_row;
  logic                 w_t, hit, t_eff, dummy;
  assign w_bank_ok = {1'b0, bus.wr_bank}  < BANK_LIM;
  assign r_bank_ok = {1'b0, bus.ref_bank} < BANK_LIM;
  assign c_bank_ok = {1'b0, bus.clr_bank} < BANK_LIM;
  assign w_b = w_bank_ok ? bus.wr_bank : '0;
  assign r_b = r_bank_ok ? bus.ref_bank : '0;
  assign w_ok = bus.wr_valid & idle & w_bank_ok;
  assign r_ok = bus.ref_req_valid & idle;
  assign c_ok = bus.clr_valid & idle & c_bank_ok;
  assign {w_seg, w_off} = bus.wr_row;
  assign w_t   = touched[w_b][w_seg];
  assign w_spr = spr[w_b][w_seg];
  assign w_new = w_t ? (w_off > w_spr ? w_off : w_spr) : w_off;
  assign r_row = rcnt[r_b];
  assign {r_seg, r_off} = r_row;
  // Same-cycle write to the refreshed entry is folded in so a just-written row is never skipped
  assign hit     = w_ok & (bus.wr_bank == bus.ref_bank) & (w_seg == r_seg);
  assign t_eff   = hit | touched[r_b][r_seg];
  assign spr_eff = hit ? w_new : spr[r_b][r_seg];
  assign dummy   = bus.skip_en & r_bank_ok & (!t_eff | (r_off > spr_eff));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = state == IDLE ? (c_ok ? CLEAR : IDLE) : (&clr_idx ? IDLE : CLEAR);
  always_comb begin
    idle              = state == IDLE;
    bus.wr_ready      = idle;
    bus.ref_req_ready = idle;
    bus.clr_ready     = idle;
    bus.clr_done      = !idle & (&clr_idx);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        touched[b] <= '0;
        rcnt[b]    <= '0;
        for (int s = 0; s < SEGS; s++) spr[b][s] <= '0;
      end
      clr_idx <= '0;
      clr_sel <= '0;
    end else begin
      if (w_ok) begin
        touched[w_b][w_seg] <= 1'b1;
        spr[w_b][w_seg]     <= w_new;
      end
      if (r_ok & r_bank_ok) rcnt[r_b] <= r_row + 1'b1;
      if (c_ok) clr_sel <= bus.clr_bank;
      clr_idx <= state == CLEAR ? clr_idx + 1'b1 : '0;
      if (state == CLEAR) begin
        touched[clr_sel][clr_idx] <= 1'b0;
        spr[clr_sel][clr_idx]     <= '0;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.ref_rsp_valid <= 1'b0;
      bus.ref_rsp_bank  <= '0;
      bus.ref_rsp_row   <= '0;
      bus.ref_rsp_dummy <= 1'b0;
      bus.dummy_cnt     <= '0;
    end else begin
      bus.ref_rsp_valid <= r_ok;
      if (r_ok) begin
        bus.ref_rsp_bank  <= bus.ref_bank;
        bus.ref_rsp_row   <= r_bank_ok ? r_row : '0;
        bus.ref_rsp_dummy <= dummy;
      end
      if (bus.ref_rsp_valid & bus.ref_rsp_dummy & ~&bus.dummy_cnt) bus.dummy_cnt <= bus.dummy_cnt + 1'b1;
    end
endmodule

// File: tb/tb_wupr_mb.sv
// tb_wupr_mb: directed scenarios plus randomized traffic against a max-offset-per-segment model
module tb_wupr_mb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  always #5 clk = ~clk;
  wupr_mb_if m_if ();
  wupr_mb_if #(.CNT_WIDTH(4)) s_if ();
  wupr_mb dut (.clk(clk), .rst_n(rst_n), .bus(m_if));
  wupr_mb #(.BANKS(3), .CNT_WIDTH(4)) dut_s (.clk(clk), .rst_n(rst_n), .bus(s_if));

  task automatic idle_inputs;
    m_if.wr_valid = 0; m_if.ref_req_valid = 0; m_if.clr_valid = 0;
    m_if.wr_bank = 0; m_if.wr_row = 0; m_if.ref_bank = 0; m_if.clr_bank = 0;
    s_if.wr_valid = 0; s_if.ref_req_valid = 0; s_if.clr_valid = 0;
    s_if.wr_bank = 0; s_if.wr_row = 0; s_if.ref_bank = 0; s_if.clr_bank = 0;
  endtask

  task automatic cyc(input logic wv, input logic [1:0] wb, input logic [15:0] wr,
                     input logic rv, input logic [1:0] rb, input logic cv, input logic [1:0] cb);
    m_if.wr_valid = wv; m_if.wr_bank = wb; m_if.wr_row = wr;
    m_if.ref_req_valid = rv; m_if.ref_bank = rb;
    m_if.clr_valid = cv; m_if.clr_bank = cb;
    @(negedge clk);
    m_if.wr_valid = 0; m_if.ref_req_valid = 0; m_if.clr_valid = 0;
  endtask

  task automatic reset_dut;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    m_if.skip_en = 1; s_if.skip_en = 1;
    idle_inputs();
    #2;
    checks++;
    if ({m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready, m_if.ref_rsp_valid, m_if.ref_rsp_dummy,
         m_if.clr_done} !== 6'b111000 || m_if.dummy_cnt !== 0 || m_if.ref_rsp_row !== 0) begin
      failures++;
      $display("FAIL reset_in: rdy=%b%b%b rsp=%b dmy=%b done=%b cnt=%0d row=%h want rdy=111 rest 0",
               m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready, m_if.ref_rsp_valid,
               m_if.ref_rsp_dummy, m_if.clr_done, m_if.dummy_cnt, m_if.ref_rsp_row);
    end
    reset_dut();
    checks++;
    if ({m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready, m_if.ref_rsp_valid, m_if.clr_done} !== 5'b11100) begin
      failures++;
      $display("FAIL reset_out: rdy=%b%b%b rsp=%b done=%b want 111 0 0",
               m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready, m_if.ref_rsp_valid, m_if.clr_done);
    end
  endtask

  task automatic test_untouched;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      exp_cnt++;
      checks++;
      if (m_if.ref_rsp_valid !== 1 || m_if.ref_rsp_row !== 16'(i) || m_if.ref_rsp_dummy !== 1 || m_if.ref_rsp_bank !== 0) begin
        failures++;
        $display("FAIL untouched_%0d: v=%b row=%h d=%b bank=%0d want v=1 row=%h d=1 bank=0",
                 i, m_if.ref_rsp_valid, m_if.ref_rsp_row, m_if.ref_rsp_dummy, m_if.ref_rsp_bank, i);
      end
    end
    @(negedge clk);
    checks++;
    if (m_if.ref_rsp_valid !== 0 || m_if.dummy_cnt !== 32'(exp_cnt)) begin
      failures++;
      $display("FAIL untouched_cnt: v=%b cnt=%0d want v=0 cnt=%0d", m_if.ref_rsp_valid, m_if.dummy_cnt, exp_cnt);
    end
  endtask

  task automatic test_peak;
    int bad = 0;
    cyc(1, 1, 16'h0405, 0, 0, 0, 0);
    for (int i = 0; i < 16'h0400; i++) begin
      cyc(0, 0, 0, 1, 1, 0, 0);
      exp_cnt++;
      if (m_if.ref_rsp_dummy !== 1 || m_if.ref_rsp_row !== 16'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL peak_ffwd: bad=%0d want 0", bad);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 1, 0, 0);
      if (i > 5) exp_cnt++;
      checks++;
      if (m_if.ref_rsp_valid !== 1 || m_if.ref_rsp_row !== 16'(16'h0400 + i) || m_if.ref_rsp_dummy !== (i > 5)) begin
        failures++;
        $display("FAIL peak_row%h: v=%b row=%h d=%b want v=1 d=%b",
                 16'h0400 + i, m_if.ref_rsp_valid, m_if.ref_rsp_row, m_if.ref_rsp_dummy, i > 5);
      end
    end
  endtask

  task automatic test_bypass;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 2, 0, 0);
      exp_cnt++;
    end
    cyc(1, 2, 16'h0003, 1, 2, 0, 0);
    checks++;
    if (m_if.ref_rsp_row !== 16'h0003 || m_if.ref_rsp_dummy !== 0) begin
      failures++;
      $display("FAIL bypass: row=%h d=%b want row=0003 d=0", m_if.ref_rsp_row, m_if.ref_rsp_dummy);
    end
    cyc(0, 0, 0, 1, 2, 0, 0);
    exp_cnt++;
    checks++;
    if (m_if.ref_rsp_row !== 16'h0004 || m_if.ref_rsp_dummy !== 1) begin
      failures++;
      $display("FAIL bypass_next: row=%h d=%b want row=0004 d=1", m_if.ref_rsp_row, m_if.ref_rsp_dummy);
    end
  endtask

  task automatic test_skip_off;
    m_if.skip_en = 0;
    cyc(0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (m_if.ref_rsp_row !== 16'h0004 || m_if.ref_rsp_dummy !== 0) begin
      failures++;
      $display("FAIL skip_off: row=%h d=%b want row=0004 d=0", m_if.ref_rsp_row, m_if.ref_rsp_dummy);
    end
    @(negedge clk);
    checks++;
    if (m_if.dummy_cnt !== 32'(exp_cnt)) begin
      failures++;
      $display("FAIL skip_off_cnt: cnt=%0d want %0d", m_if.dummy_cnt, exp_cnt);
    end
    m_if.skip_en = 1;
  endtask

  task automatic test_clear;
    cyc(1, 3, 16'h0010, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 3, 0, 0);
      checks++;
      if (m_if.ref_rsp_row !== 16'(i) || m_if.ref_rsp_dummy !== 0) begin
        failures++;
        $display("FAIL pre_clear_%0d: row=%h d=%b want d=0", i, m_if.ref_rsp_row, m_if.ref_rsp_dummy);
      end
    end
    cyc(0, 0, 0, 0, 0, 1, 3);
    for (int i = 1; i <= 64; i++) begin
      checks++;
      if ({m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready} !== 3'b000 || m_if.clr_done !== (i == 64)) begin
        failures++;
        $display("FAIL clear_cyc%0d: rdy=%b%b%b done=%b want rdy=000 done=%b",
                 i, m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready, m_if.clr_done, i == 64);
      end
      if (i == 10) begin
        m_if.wr_valid = 1; m_if.wr_bank = 3; m_if.wr_row = 16'h0011;
        m_if.ref_req_valid = 1; m_if.ref_bank = 3;
      end
      @(negedge clk);
      m_if.wr_valid = 0; m_if.ref_req_valid = 0;
      if (i == 10) begin
        checks++;
        if (m_if.ref_rsp_valid !== 0) begin
          failures++;
          $display("FAIL clear_no_rsp: v=%b want 0", m_if.ref_rsp_valid);
        end
      end
    end
    checks++;
    if ({m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready} !== 3'b111 || m_if.clr_done !== 0) begin
      failures++;
      $display("FAIL clear_end: rdy=%b%b%b done=%b want 111 0",
               m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready, m_if.clr_done);
    end
    for (int r = 4; r <= 16'h0011; r++) begin
      cyc(0, 0, 0, 1, 3, 0, 0);
      exp_cnt++;
      if (r >= 16'h0010) begin
        checks++;
        if (m_if.ref_rsp_row !== 16'(r) || m_if.ref_rsp_dummy !== 1) begin
          failures++;
          $display("FAIL post_clear_%h: row=%h d=%b want d=1", r, m_if.ref_rsp_row, m_if.ref_rsp_dummy);
        end
      end
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 20; i++) begin
      s_if.ref_req_valid = 1; s_if.ref_bank = 0;
      @(negedge clk);
      s_if.ref_req_valid = 0;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (s_if.dummy_cnt !== 4'hF) begin
      failures++;
      $display("FAIL saturate: cnt=%h want f", s_if.dummy_cnt);
    end
  endtask

  task automatic test_bad_bank;
    s_if.wr_valid = 1; s_if.wr_bank = 3; s_if.wr_row = 16'h0000;
    s_if.ref_req_valid = 1; s_if.ref_bank = 3;
    s_if.clr_valid = 1; s_if.clr_bank = 3;
    @(negedge clk);
    s_if.wr_valid = 0; s_if.ref_req_valid = 0; s_if.clr_valid = 0;
    checks++;
    if (s_if.ref_rsp_valid !== 1 || s_if.ref_rsp_bank !== 2'd3 || s_if.ref_rsp_dummy !== 0 ||
        {s_if.wr_ready, s_if.ref_req_ready, s_if.clr_ready} !== 3'b111) begin
      failures++;
      $display("FAIL bad_bank: v=%b bank=%0d d=%b rdy=%b%b%b want v=1 bank=3 d=0 rdy=111",
               s_if.ref_rsp_valid, s_if.ref_rsp_bank, s_if.ref_rsp_dummy,
               s_if.wr_ready, s_if.ref_req_ready, s_if.clr_ready);
    end
    @(negedge clk);
    checks++;
    if (s_if.clr_ready !== 1 || s_if.clr_done !== 0) begin
      failures++;
      $display("FAIL bad_bank_clr: rdy=%b done=%b want 1 0", s_if.clr_ready, s_if.clr_done);
    end
  endtask

  task automatic test_reset_mid_clear;
    int done_seen = 0;
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready} !== 3'b111 || m_if.clr_done !== 0 ||
        m_if.ref_rsp_valid !== 0 || m_if.dummy_cnt !== 0 || s_if.dummy_cnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_clear: rdy=%b%b%b done=%b v=%b cnt=%0d scnt=%0d want 111 0 0 0 0",
               m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready, m_if.clr_done,
               m_if.ref_rsp_valid, m_if.dummy_cnt, s_if.dummy_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    exp_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      if (m_if.clr_done !== 0) done_seen++;
      @(negedge clk);
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL reset_no_done: pulses=%0d want 0", done_seen);
    end
    for (int r = 0; r < 4; r++) cyc(0, 0, 0, 1, 2, 0, 0);
    checks++;
    if (m_if.ref_rsp_row !== 16'h0003 || m_if.ref_rsp_dummy !== 1) begin
      failures++;
      $display("FAIL reset_wipe: row=%h d=%b want row=0003 d=1", m_if.ref_rsp_row, m_if.ref_rsp_dummy);
    end
  endtask

  task automatic test_random;
    int mo[4][64];
    int rc[4];
    int busy = 0, mcnt = 0, erow = 0, eb = 0, wb, wrow, rb, cb, row;
    bit ev = 0, ed = 0, wv, rv, cv, sk;
    reset_dut();
    for (int b = 0; b < 4; b++) begin
      rc[b] = 0;
      for (int s = 0; s < 64; s++) mo[b][s] = -1;
    end
    for (int it = 0; it < 3000; it++) begin
      checks++;
      if ({m_if.wr_ready, m_if.ref_req_ready, m_if.clr_ready} !== {3{busy == 0}} || m_if.clr_done !== (busy == 1)) begin
        failures++;
        $display("FAIL rnd_ctl@%0d: rdy=%b%b%b done=%b want rdy=%b done=%b", it, m_if.wr_ready,
                 m_if.ref_req_ready, m_if.clr_ready, m_if.clr_done, busy == 0, busy == 1);
      end
      checks++;
      if (m_if.dummy_cnt !== 32'(mcnt)) begin
        failures++;
        $display("FAIL rnd_cnt@%0d: cnt=%0d want %0d", it, m_if.dummy_cnt, mcnt);
      end
      checks++;
      if (m_if.ref_rsp_valid !== ev || (ev && (m_if.ref_rsp_row !== 16'(erow) ||
          m_if.ref_rsp_bank !== 2'(eb) || m_if.ref_rsp_dummy !== ed))) begin
        failures++;
        $display("FAIL rnd_rsp@%0d: v=%b bank=%0d row=%h d=%b want v=%b bank=%0d row=%h d=%b", it,
                 m_if.ref_rsp_valid, m_if.ref_rsp_bank, m_if.ref_rsp_row, m_if.ref_rsp_dummy, ev, eb, erow, ed);
      end
      if (ev && ed) mcnt++;
      sk = ($urandom % 8) != 0;
      wv = $urandom % 2;
      wb = $urandom_range(0, 3);
      wrow = ($urandom % 4 == 0) ? int'($urandom % 65536) : (rc[wb] + int'($urandom_range(0, 5))) % 65536;
      rv = ($urandom % 4) != 0;
      rb = $urandom_range(0, 3);
      cv = ($urandom % 100) == 0;
      cb = $urandom_range(0, 3);
      m_if.skip_en = sk;
      m_if.wr_valid = wv; m_if.wr_bank = 2'(wb); m_if.wr_row = 16'(wrow);
      m_if.ref_req_valid = rv; m_if.ref_bank = 2'(rb);
      m_if.clr_valid = cv; m_if.clr_bank = 2'(cb);
      ev = 0;
      if (busy == 0) begin
        if (wv && (wrow % 1024) > mo[wb][wrow / 1024]) mo[wb][wrow / 1024] = wrow % 1024;
        if (rv) begin
          row = rc[rb];
          ev = 1; eb = rb; erow = row;
          ed = sk && (row % 1024) > mo[rb][row / 1024];
          rc[rb] = (row + 1) % 65536;
        end
        if (cv) begin
          for (int s = 0; s < 64; s++) mo[cb][s] = -1;
          busy = 64;
        end
      end else busy--;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_untouched();
    test_peak();
    test_bypass();
    test_skip_off();
    test_clear();
    test_saturate();
    test_bad_bank();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
